pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// Central stall/flush controller for the 5-stage pipeline. Drives the stall/flush inputs of the
// IF/ID, ID/EX, EX/MEM and MEM/WB segment registers and the PC hold. Resolves load-use hazards,
// branch/jump redirects, multi-cycle data-memory waits and debug halt/single-step.
// Keeps saturating stall/flush performance counters.
// PARAMETERS
// MEM_TIMEOUT  64     wait cycles in MEM_WAIT before declaring a memory timeout (>=2)
// CNT_W        32     width of performance counters
// LOAD_SEL     2'b10  rf_wd_sel encoding meaning "write-back from data memory"
// PORTS
// clk           in  1      clock, all state updates on posedge
// rst           in  1      synchronous, active-high reset
// id_rf_ra0/1   in  5      ID-stage source register addresses
// id_rf_re0/1   in  1      ID-stage source read enables
// ex_rf_wa      in  5      EX-stage destination register
// ex_rf_we      in  1      EX-stage register write enable
// ex_rf_wd_sel  in  2      EX-stage write-back select
// ex_pc_sel     in  2      EX-stage PC select; nonzero = taken branch/jal/jalr redirect
// mem_dm_req    in  1      MEM-stage data-memory access (load or store) in progress
// mem_dm_ready  in  1      data memory completes the MEM-stage access this cycle
// dbg_halt      in  1      level: request/hold halt
// dbg_step      in  1      pulse: execute one cycle while halted
// stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out 1  hold PC / segment register
// flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb out 1  load bubble into segment register
// halted        out 1      state == HALT
// mem_timeout   out 1      sticky; set on wait timeout, cleared only by rst
// stall_cnt     out CNT_W  cycles with stall_pc=1, excluding HALT; saturates
// flush_cnt     out CNT_W  cycles with a branch flush; saturates
// BEHAVIOUR
// - Stall/flush outputs are combinational from state + inputs (Mealy); state, counters, mem_timeout registered.
// - rst=1: all stalls 0, all four flushes 1; next state RUN; counters 0; mem_timeout 0; wait count 0.
// - States: RUN, MEM_WAIT, HALT, STEP. STEP drives same outputs as RUN.
// - lu = ex_rf_we & ex_rf_wd_sel==LOAD_SEL & ex_rf_wa!=0 & ((id_rf_re0 & id_rf_ra0==ex_rf_wa) | (id_rf_re1 & id_rf_ra1==ex_rf_wa)).
// - mw = mem_dm_req & ~mem_dm_ready. br = ex_pc_sel!=0.
// - RUN/STEP priority: mw > br > lu.
//   mw: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem=1, flush_mem_wb=1; next MEM_WAIT, wait count=1.
//   br: flush_if_id=flush_id_ex=1, no stalls (lu ignored, ID instr is squashed).
//   lu: stall_pc=stall_if_id=1, flush_id_ex=1 (one bubble; EX load advances, hazard clears next cycle).
//   none: all 0.
// - RUN next: mw->MEM_WAIT, else dbg_halt->HALT, else RUN. STEP next: mw->MEM_WAIT, else dbg_halt->HALT, else RUN.
// - MEM_WAIT: while mem_dm_ready=0 outputs as mw case, br/lu flushes suppressed; wait count++.
//   mem_dm_ready=1: outputs per RUN rules with mw=0 (br/lu evaluated), next RUN. dbg_halt seen next cycle.
//   wait count reaching MEM_TIMEOUT with ready=0: set mem_timeout, next HALT.
// - HALT: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem=1, flush_mem_wb=1.
//   mem_timeout=1 -> stay HALT. Else ~dbg_halt -> RUN; else dbg_step -> STEP; else HALT.
// - stall_cnt +1 per cycle stall_pc=1 and state!=HALT; flush_cnt +1 per cycle br flush taken; both saturate at all-ones.
// - ex_rf_wa==0 never causes lu. Simultaneous dbg_halt and mw: MEM_WAIT first.
// TESTING
// - rst 1 cycle -> all flush=1, stalls=0; after release state RUN, counters 0, halted=0.
// - EX: wa=5,we=1,wd_sel=2'b10; ID: ra0=5,re0=1 -> 1 cycle stall_pc=stall_if_id=flush_id_ex=1, stall_cnt=1.
// - Same plus ex_pc_sel=2'b01 -> flush_if_id=flush_id_ex=1, stall_pc=0, flush_cnt=1.
// - mem_dm_req=1, ready low 3 cycles then high -> 3 full-stall cycles with flush_mem_wb=1, release on 4th; stall_cnt=3.
// - MEM_TIMEOUT=4, ready never -> mem_timeout=1, halted=1 after 4 wait cycles; dbg_halt=0 keeps HALT until rst.
// - dbg_halt=1 -> HALT; dbg_step pulse -> exactly one unstalled cycle, back to HALT; dbg_halt=0 -> RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Bundle between the 5-stage pipeline datapath and the hazard
//                controller. Carries the ID/EX/MEM hazard sources and debug
//                requests toward the controller, and the stall/flush controls,
//                status flags and performance counters back to the pipeline.
//  Ports       : master - pipeline side (drives hazard sources, takes controls)
//                slave  - controller side (takes hazard sources, drives controls)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   // hazard sources
   logic [4:0]       id_rf_ra0;
   logic [4:0]       id_rf_ra1;
   logic             id_rf_re0;
   logic             id_rf_re1;
   logic [4:0]       ex_rf_wa;
   logic             ex_rf_we;
   logic [1:0]       ex_rf_wd_sel;
   logic [1:0]       ex_pc_sel;
   logic             mem_dm_req;
   logic             mem_dm_ready;
   logic             dbg_halt;
   logic             dbg_step;
   // pipeline controls
   logic             stall_pc;
   logic             stall_if_id;
   logic             stall_id_ex;
   logic             stall_ex_mem;
   logic             flush_if_id;
   logic             flush_id_ex;
   logic             flush_ex_mem;
   logic             flush_mem_wb;
   // status
   logic             halted;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_rf_ra0, id_rf_ra1, id_rf_re0, id_rf_re1,
             ex_rf_wa, ex_rf_we, ex_rf_wd_sel, ex_pc_sel,
             mem_dm_req, mem_dm_ready, dbg_halt, dbg_step,
      input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
             flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
             halted, mem_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rf_ra0, id_rf_ra1, id_rf_re0, id_rf_re1,
             ex_rf_wa, ex_rf_we, ex_rf_wd_sel, ex_pc_sel,
             mem_dm_req, mem_dm_ready, dbg_halt, dbg_step,
      output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
             flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
             halted, mem_timeout, stall_cnt, flush_cnt
   );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Central stall/flush controller for the 5-stage pipeline.
//                Resolves load-use hazards, branch/jump redirects, multi-cycle
//                data-memory waits and debug halt/single-step, and keeps
//                saturating stall/flush performance counters.
//  Ports       : clk  - clock, all state on rising edge
//                rst  - synchronous active-high reset
//                hz   - pipe_hazard_ctrl_if.slave: hazard sources in,
//                       stall_*/flush_* controls, halted, mem_timeout,
//                       stall_cnt, flush_cnt out
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
   parameter int         MEM_TIMEOUT = 64,
   parameter int         CNT_W       = 32,
   parameter logic [1:0] LOAD_SEL    = 2'b10
) (
   input  wire logic             clk,
   input  wire logic             rst,
   pipe_hazard_ctrl_if.slave     hz
);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MEM_WAIT = 2'd1,
      S_HALT     = 2'd2,
      S_STEP     = 2'd3
   } state_t;

   localparam int                WCNT_W      = $clog2(MEM_TIMEOUT + 1);
   // Wait count value whose increment reaches MEM_TIMEOUT.
   localparam logic [WCNT_W-1:0] c_wait_last = WCNT_W'(MEM_TIMEOUT - 1);

   state_t            state_q,    state_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_q,  timeout_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic w_lu;
   logic w_mw;
   logic w_br;
   logic w_full_stall;   // freeze everything, bubble into MEM/WB
   logic w_eval_hz;      // branch/load-use resolution active this cycle
   logic w_br_take;
   logic w_lu_take;

   assign w_lu = hz.ex_rf_we && (hz.ex_rf_wd_sel == LOAD_SEL) && (hz.ex_rf_wa != 5'd0) &&
                 ((hz.id_rf_re0 && (hz.id_rf_ra0 == hz.ex_rf_wa)) ||
                  (hz.id_rf_re1 && (hz.id_rf_ra1 == hz.ex_rf_wa)));
   assign w_mw = hz.mem_dm_req && !hz.mem_dm_ready;
   assign w_br = (hz.ex_pc_sel != 2'b00);

   always_comb begin
      w_full_stall = 1'b0;
      w_eval_hz    = 1'b0;
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      timeout_d    = timeout_q;

      if (rst) begin
         state_d    = S_RUN;
         wait_cnt_d = '0;
         timeout_d  = 1'b0;
      end else begin
         case (state_q)
            S_RUN, S_STEP: begin
               // A pending memory wait beats a simultaneous halt request.
               if (w_mw) begin
                  w_full_stall = 1'b1;
                  state_d      = S_MEM_WAIT;
                  wait_cnt_d   = WCNT_W'(1);
               end else begin
                  w_eval_hz = 1'b1;
                  state_d   = hz.dbg_halt ? S_HALT : S_RUN;
               end
            end
            S_MEM_WAIT: begin
               if (!hz.mem_dm_ready) begin
                  w_full_stall = 1'b1;
                  wait_cnt_d   = wait_cnt_q + WCNT_W'(1);
                  if (wait_cnt_q >= c_wait_last) begin
                     timeout_d = 1'b1;
                     state_d   = S_HALT;
                  end
               end else begin
                  // Halt is only honoured once back in RUN.
                  w_eval_hz = 1'b1;
                  state_d   = S_RUN;
               end
            end
            S_HALT: begin
               w_full_stall = 1'b1;
               if (timeout_q) begin
                  state_d = S_HALT;
               end else if (!hz.dbg_halt) begin
                  state_d = S_RUN;
               end else if (hz.dbg_step) begin
                  state_d = S_STEP;
               end
            end
            default: begin
               state_d = S_RUN;
            end
         endcase
      end
   end

   // Branch squashes the ID instruction, so a load-use on it is moot.
   assign w_br_take = w_eval_hz && w_br;
   assign w_lu_take = w_eval_hz && !w_br && w_lu;

   always_comb begin
      hz.stall_pc     = 1'b0;
      hz.stall_if_id  = 1'b0;
      hz.stall_id_ex  = 1'b0;
      hz.stall_ex_mem = 1'b0;
      hz.flush_if_id  = 1'b1;
      hz.flush_id_ex  = 1'b1;
      hz.flush_ex_mem = 1'b1;
      hz.flush_mem_wb = 1'b1;
      if (!rst) begin
         hz.stall_pc     = w_full_stall || w_lu_take;
         hz.stall_if_id  = w_full_stall || w_lu_take;
         hz.stall_id_ex  = w_full_stall;
         hz.stall_ex_mem = w_full_stall;
         hz.flush_if_id  = w_br_take;
         hz.flush_id_ex  = w_br_take || w_lu_take;
         hz.flush_ex_mem = 1'b0;
         hz.flush_mem_wb = w_full_stall;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (rst) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         // Halt cycles are debugger time, not pipeline stalls.
         if (hz.stall_pc && (state_q != S_HALT) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (w_br_take && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
   end

   assign hz.halted      = (state_q == S_HALT);
   assign hz.mem_timeout = timeout_q;
   assign hz.stall_cnt   = stall_cnt_q;
   assign hz.flush_cnt   = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed-vector bench for pipe_hazard_ctrl. Each cycle the
//                stimulus drives one input vector and queues the hand-derived
//                response; a negedge monitor pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 3;

   localparam logic [3:0] ST_NONE = 4'b0000;
   localparam logic [3:0] ST_LU   = 4'b1100;
   localparam logic [3:0] ST_FULL = 4'b1111;
   localparam logic [3:0] FL_NONE = 4'b0000;
   localparam logic [3:0] FL_RST  = 4'b1111;
   localparam logic [3:0] FL_BR   = 4'b1100;
   localparam logic [3:0] FL_LU   = 4'b0100;
   localparam logic [3:0] FL_FULL = 4'b0001;

   typedef struct {
      logic       rst;
      logic [4:0] ra0, ra1, wa;
      logic       re0, re1, we;
      logic [1:0] wd_sel, pc_sel;
      logic       req, rdy, halt, step;
   } in_t;

   typedef struct {
      logic             chk;
      string            nm;
      logic [3:0]       stl;
      logic [3:0]       fl;
      logic             h;
      logic             m;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t e;

   pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT (4),
      .CNT_W       (CNT_W),
      .LOAD_SEL    (2'b10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz.slave)
   );

   always #5 clk = ~clk;

   function automatic in_t idle();
      in_t v;
      v = '{rst: 1'b0, ra0: 5'd0, ra1: 5'd0, wa: 5'd0, re0: 1'b0, re1: 1'b0, we: 1'b0,
            wd_sel: 2'b00, pc_sel: 2'b00, req: 1'b0, rdy: 1'b0, halt: 1'b0, step: 1'b0};
      return v;
   endfunction

   function automatic in_t ex_id(input logic [4:0] wa, input logic [4:0] ra0, input logic re0,
                                 input logic [4:0] ra1, input logic re1, input logic [1:0] sel);
      in_t v;
      v        = idle();
      v.wa     = wa;
      v.we     = 1'b1;
      v.wd_sel = sel;
      v.ra0    = ra0;
      v.re0    = re0;
      v.ra1    = ra1;
      v.re1    = re1;
      return v;
   endfunction

   // Drive one cycle of inputs and queue its expected response.
   task automatic cyc(input string nm, input in_t v, input logic [3:0] stl, input logic [3:0] fl,
                      input logic h, input logic m, input int sc, input int fc);
      exp_t x;
      rst             = v.rst;
      hz.id_rf_ra0    = v.ra0;
      hz.id_rf_ra1    = v.ra1;
      hz.id_rf_re0    = v.re0;
      hz.id_rf_re1    = v.re1;
      hz.ex_rf_wa     = v.wa;
      hz.ex_rf_we     = v.we;
      hz.ex_rf_wd_sel = v.wd_sel;
      hz.ex_pc_sel    = v.pc_sel;
      hz.mem_dm_req   = v.req;
      hz.mem_dm_ready = v.rdy;
      hz.dbg_halt     = v.halt;
      hz.dbg_step     = v.step;
      x.chk = (nm != "-");
      x.nm  = nm;
      x.stl = stl;
      x.fl  = fl;
      x.h   = h;
      x.m   = m;
      x.sc  = CNT_W'(sc);
      x.fc  = CNT_W'(fc);
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.chk) begin
            checks++;
            if ({hz.stall_pc, hz.stall_if_id, hz.stall_id_ex, hz.stall_ex_mem,
                 hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem, hz.flush_mem_wb,
                 hz.halted, hz.mem_timeout, hz.stall_cnt, hz.flush_cnt}
                !== {e.stl, e.fl, e.h, e.m, e.sc, e.fc}) begin
               errors++;
               $display("FAIL %s: got stl=%b fl=%b h=%b mto=%b sc=%0d fc=%0d, expected stl=%b fl=%b h=%b mto=%b sc=%0d fc=%0d",
                        e.nm, {hz.stall_pc, hz.stall_if_id, hz.stall_id_ex, hz.stall_ex_mem},
                        {hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem, hz.flush_mem_wb},
                        hz.halted, hz.mem_timeout, hz.stall_cnt, hz.flush_cnt,
                        e.stl, e.fl, e.h, e.m, e.sc, e.fc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish before 100000");
      $fatal(1);
   end

   initial begin
      in_t v;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // reset and plain run
      v = idle(); v.rst = 1'b1;
      cyc("-",          v,      ST_NONE, FL_RST,  0, 0, 0, 0);
      cyc("reset",      v,      ST_NONE, FL_RST,  0, 0, 0, 0);
      cyc("idle",       idle(), ST_NONE, FL_NONE, 0, 0, 0, 0);

      // load-use detection and its exclusions
      cyc("lu_ra0",     ex_id(5, 5, 1, 0, 0, 2'b10), ST_LU,   FL_LU,   0, 0, 0, 0);
      cyc("lu_clear",   idle(),                      ST_NONE, FL_NONE, 0, 0, 1, 0);
      cyc("lu_ra1",     ex_id(7, 0, 0, 7, 1, 2'b10), ST_LU,   FL_LU,   0, 0, 1, 0);
      cyc("lu1_clear",  idle(),                      ST_NONE, FL_NONE, 0, 0, 2, 0);
      cyc("no_re",      ex_id(5, 5, 0, 0, 0, 2'b10), ST_NONE, FL_NONE, 0, 0, 2, 0);
      cyc("wa_zero",    ex_id(0, 0, 1, 0, 1, 2'b10), ST_NONE, FL_NONE, 0, 0, 2, 0);
      cyc("not_load",   ex_id(5, 5, 1, 0, 0, 2'b01), ST_NONE, FL_NONE, 0, 0, 2, 0);

      // branch redirects
      v = ex_id(5, 5, 1, 0, 0, 2'b10); v.pc_sel = 2'b01;
      cyc("br_over_lu", v,      ST_NONE, FL_BR,   0, 0, 2, 0);
      cyc("br_clear",   idle(), ST_NONE, FL_NONE, 0, 0, 2, 1);
      v = idle(); v.pc_sel = 2'b11;
      cyc("br_only",    v,      ST_NONE, FL_BR,   0, 0, 2, 1);
      cyc("br2_clear",  idle(), ST_NONE, FL_NONE, 0, 0, 2, 2);

      // memory wait, three stalled cycles then ready
      v = idle(); v.req = 1'b1;
      cyc("mw_enter",   v,      ST_FULL, FL_FULL, 0, 0, 2, 2);
      cyc("mw_wait1",   v,      ST_FULL, FL_FULL, 0, 0, 3, 2);
      cyc("mw_wait2",   v,      ST_FULL, FL_FULL, 0, 0, 4, 2);
      v.rdy = 1'b1;
      cyc("mw_release", v,      ST_NONE, FL_NONE, 0, 0, 5, 2);
      cyc("mw_after",   idle(), ST_NONE, FL_NONE, 0, 0, 5, 2);

      // memory wait outranks branch; branch resolves on the ready cycle
      v = ex_id(5, 5, 1, 0, 0, 2'b10); v.pc_sel = 2'b01; v.req = 1'b1;
      cyc("mw_over_br", v,      ST_FULL, FL_FULL, 0, 0, 5, 2);
      v.rdy = 1'b1;
      cyc("mw_rdy_br",  v,      ST_NONE, FL_BR,   0, 0, 6, 2);
      cyc("mwbr_after", idle(), ST_NONE, FL_NONE, 0, 0, 6, 3);

      // stall counter saturation at 7
      v = ex_id(5, 5, 1, 0, 0, 2'b10);
      cyc("sat_a",      v,      ST_LU,   FL_LU,   0, 0, 6, 3);
      cyc("sat_b",      v,      ST_LU,   FL_LU,   0, 0, 7, 3);
      cyc("sat_c",      v,      ST_LU,   FL_LU,   0, 0, 7, 3);
      cyc("sat_hold",   idle(), ST_NONE, FL_NONE, 0, 0, 7, 3);

      // reset clears counters
      v = idle(); v.rst = 1'b1;
      cyc("rst2",       v,      ST_NONE, FL_RST,  0, 0, 7, 3);

      // halt with simultaneous memory wait, then halt/step/resume
      v = idle(); v.req = 1'b1; v.halt = 1'b1;
      cyc("hlt_mw",     v,      ST_FULL, FL_FULL, 0, 0, 0, 0);
      v.rdy = 1'b1;
      cyc("hlt_mw_rdy", v,      ST_NONE, FL_NONE, 0, 0, 1, 0);
      v = idle(); v.halt = 1'b1;
      cyc("hlt_run",    v,      ST_NONE, FL_NONE, 0, 0, 1, 0);
      cyc("halted",     v,      ST_FULL, FL_FULL, 1, 0, 1, 0);
      v.step = 1'b1;
      cyc("step_req",   v,      ST_FULL, FL_FULL, 1, 0, 1, 0);
      v.step = 1'b0;
      cyc("step_cyc",   v,      ST_NONE, FL_NONE, 0, 0, 1, 0);
      cyc("step_back",  v,      ST_FULL, FL_FULL, 1, 0, 1, 0);
      cyc("resume_req", idle(), ST_FULL, FL_FULL, 1, 0, 1, 0);
      cyc("resumed",    idle(), ST_NONE, FL_NONE, 0, 0, 1, 0);

      // memory timeout after four wait cycles, sticky until reset
      v = idle(); v.req = 1'b1;
      cyc("to_w1",      v,      ST_FULL, FL_FULL, 0, 0, 1, 0);
      cyc("to_w2",      v,      ST_FULL, FL_FULL, 0, 0, 2, 0);
      cyc("to_w3",      v,      ST_FULL, FL_FULL, 0, 0, 3, 0);
      cyc("to_w4",      v,      ST_FULL, FL_FULL, 0, 0, 4, 0);
      cyc("to_halt",    idle(), ST_FULL, FL_FULL, 1, 1, 5, 0);
      cyc("to_stay",    idle(), ST_FULL, FL_FULL, 1, 1, 5, 0);
      v = idle(); v.rst = 1'b1;
      cyc("to_rst",     v,      ST_NONE, FL_RST,  1, 1, 5, 0);
      cyc("to_cleared", idle(), ST_NONE, FL_NONE, 0, 0, 0, 0);

      @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
